// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - instruction fetch/decode/execute/writeback sequencer (optional SINGLE_STEP_EN adds step input and PAUSE state)
module program_sequencer #(
    parameter int PROG_LEN    = 10,
    parameter int ALU_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    output logic [3:0]  imem_addr,
    input  logic [17:0] imem_rdata,
    output logic [3:0]  op_code,
    output logic [2:0]  reg_id1,
    output logic [2:0]  reg_id2,
    output logic [7:0]  imm_value,
    output logic        alu_start,
    input  logic        alu_done,
    output logic        rf_we,
    output logic [3:0]  pc,
    output logic        busy,
    output logic        done,
    output logic        error
`ifdef SINGLE_STEP_EN
    ,
    input  logic        step
`endif
);

    localparam int          WW      = $clog2(ALU_TIMEOUT + 1);
    localparam logic [WW-1:0] TIMEOUT = WW'(ALU_TIMEOUT);
    localparam logic [3:0]  LAST    = 4'(PROG_LEN - 1);
    localparam logic [3:0]  OP_HALT = 4'b1111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
`ifdef SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    pc_q, pc_d;
    logic [3:0]    imem_addr_q, imem_addr_d;
    logic [3:0]    op_code_q, op_code_d;
    logic [2:0]    reg_id1_q, reg_id1_d;
    logic [2:0]    reg_id2_q, reg_id2_d;
    logic [7:0]    imm_value_q, imm_value_d;
    logic [WW-1:0] wait_q, wait_d;
    logic          alu_start_q, alu_start_d;
    logic          rf_we_q, rf_we_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;

    // Next-state logic; outputs are derived from the next state so they are registered in step with it
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        op_code_d   = op_code_q;
        reg_id1_d   = reg_id1_q;
        reg_id2_d   = reg_id2_q;
        imm_value_d = imm_value_q;
        wait_d      = wait_q;
        error_d     = error_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_d    = 4'd0;
                    error_d = 1'b0;
                    wait_d  = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                op_code_d   = imem_rdata[17:14];
                reg_id1_d   = imem_rdata[13:11];
                reg_id2_d   = imem_rdata[10:8];
                imm_value_d = imem_rdata[7:0];
                wait_d      = '0;
                if (imem_rdata[17:14] == OP_HALT) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (alu_done) begin
                    state_d = S_WB;
                end else begin
                    wait_d = wait_q + WW'(1);
                    if (wait_q + WW'(1) == TIMEOUT) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_WB: begin
                if (pc_q == LAST) begin
                    state_d = S_DONE;
                end else begin
                    pc_d = pc_q + 4'd1;
`ifdef SINGLE_STEP_EN
                    state_d = S_PAUSE;
`else
                    state_d = S_FETCH;
`endif
                end
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        imem_addr_d = pc_d;
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
        alu_start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
        rf_we_d     = (state_d == S_WB);
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            pc_q        <= 4'd0;
            imem_addr_q <= 4'd0;
            op_code_q   <= 4'd0;
            reg_id1_q   <= 3'd0;
            reg_id2_q   <= 3'd0;
            imm_value_q <= 8'd0;
            wait_q      <= '0;
            alu_start_q <= 1'b0;
            rf_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_addr_q <= imem_addr_d;
            op_code_q   <= op_code_d;
            reg_id1_q   <= reg_id1_d;
            reg_id2_q   <= reg_id2_d;
            imm_value_q <= imm_value_d;
            wait_q      <= wait_d;
            alu_start_q <= alu_start_d;
            rf_we_q     <= rf_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign imem_addr = imem_addr_q;
    assign op_code   = op_code_q;
    assign reg_id1   = reg_id1_q;
    assign reg_id2   = reg_id2_q;
    assign imm_value = imm_value_q;
    assign alu_start = alu_start_q;
    assign rf_we     = rf_we_q;
    assign pc        = pc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer
module tb_program_sequencer;

`ifdef SINGLE_STEP_EN
    localparam int GAP = 5;
`else
    localparam int GAP = 4;
`endif

    logic        clock = 1'b0;
    logic        resetn;
    logic        start;
    logic [3:0]  imem_addr;
    logic [17:0] imem_rdata;
    logic [3:0]  op_code;
    logic [2:0]  reg_id1;
    logic [2:0]  reg_id2;
    logic [7:0]  imm_value;
    logic        alu_start;
    logic        alu_done;
    logic        rf_we;
    logic [3:0]  pc;
    logic        busy;
    logic        done;
    logic        error;
`ifdef SINGLE_STEP_EN
    logic        step;
`endif

    logic        alu_en;
    logic        stall_en;
    logic [3:0]  stall_pc;
    logic [17:0] imem [16];

    typedef struct {
        logic [17:0] word;
        logic [3:0]  op;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [7:0]  imm;
    } vec_t;

    typedef struct packed {
        logic [3:0] pc;
        logic [3:0] op;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [7:0] imm;
    } exp_t;

    vec_t tbl [10];
    exp_t exp_q [$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int we_cnt = 0;
    int as_cnt = 0;
    int last_we = -1;
    logic gap_chk = 1'b0;

    program_sequencer dut (
        .clock      (clock),
        .resetn     (resetn),
        .start      (start),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .op_code    (op_code),
        .reg_id1    (reg_id1),
        .reg_id2    (reg_id2),
        .imm_value  (imm_value),
        .alu_start  (alu_start),
        .alu_done   (alu_done),
        .rf_we      (rf_we),
        .pc         (pc),
        .busy       (busy),
        .done       (done),
        .error      (error)
`ifdef SINGLE_STEP_EN
        ,
        .step       (step)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) imem_rdata <= imem[imem_addr];

    assign alu_done = alu_en && !(stall_en && (pc == stall_pc));

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    // Scoreboard monitor: every write-back strobe pops one expected record
    always @(negedge clock) begin
        if (resetn === 1'b1 && rf_we === 1'b1) begin
            we_cnt++;
            chk("rf_we_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_pc", int'(pc), int'(e.pc));
                chk("wb_op_code", int'(op_code), int'(e.op));
                chk("wb_reg_id1", int'(reg_id1), int'(e.r1));
                chk("wb_reg_id2", int'(reg_id2), int'(e.r2));
                chk("wb_imm_value", int'(imm_value), int'(e.imm));
            end
            if (gap_chk && last_we >= 0) chk("rf_we_gap", cyc - last_we, GAP);
            last_we = cyc;
        end
        if (alu_start === 1'b1) as_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic run_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) imem[i] = (i < 10) ? tbl[i].word : 18'h0;
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({4'(i), tbl[i].op, tbl[i].r1, tbl[i].r2, tbl[i].imm});
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("done_reached", int'(done === 1'b1), 1);
    endtask

    task automatic wait_exec(input logic [3:0] p, input int budget);
        int k = 0;
        while (!(alu_start === 1'b1 && pc == p) && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("exec_reached", int'(alu_start === 1'b1 && pc == p), 1);
    endtask

    task automatic wait_we(input int target, input int budget);
        int k = 0;
        while (we_cnt < target && k < budget) begin
            @(negedge clock);
            k++;
        end
        chk("rf_we_reached", we_cnt, target);
    endtask

    initial begin
        int w0;
        int a0;
        int c0;

        tbl[0] = '{18'b0000_001_010_00000101, 4'h0, 3'd1, 3'd2, 8'h05};
        tbl[1] = '{18'h05CA5, 4'h1, 3'd3, 3'd4, 8'hA5};
        tbl[2] = '{18'h0B8FF, 4'h2, 3'd7, 3'd0, 8'hFF};
        tbl[3] = '{18'h38700, 4'hE, 3'd0, 3'd7, 8'h00};
        tbl[4] = '{18'h1ED3C, 4'h7, 3'd5, 3'd5, 8'h3C};
        tbl[5] = '{18'h20E80, 4'h8, 3'd1, 3'd6, 8'h80};
        tbl[6] = '{18'h0D101, 4'h3, 3'd2, 3'd1, 8'h01};
        tbl[7] = '{18'h3335A, 4'hC, 3'd6, 3'd3, 8'h5A};
        tbl[8] = '{18'h1627E, 4'h5, 3'd4, 3'd2, 8'h7E};
        tbl[9] = '{18'h27FC3, 4'h9, 3'd7, 3'd7, 8'hC3};

        resetn   = 1'b0;
        start    = 1'b0;
        alu_en   = 1'b1;
        stall_en = 1'b0;
        stall_pc = 4'd0;
`ifdef SINGLE_STEP_EN
        step     = 1'b1;
`endif
        load_prog();

        // Reset state
        tick(3);
        chk("reset_outputs", int'({busy, done, error, alu_start, rf_we, pc, imem_addr,
                                    op_code, reg_id1, reg_id2, imm_value}), 0);
        resetn = 1'b1;
        tick(1);
        chk("rf_we_after_reset", int'(rf_we), 0);
        chk("idle_busy", int'(busy), 0);

        // Full 10-slot program, zero-wait datapath, start glitch mid-run ignored
        push_exp(10);
        gap_chk = 1'b1;
        last_we = -1;
        w0 = we_cnt;
        run_start();
        chk("fetch_busy", int'(busy), 1);
        chk("fetch_addr", int'(imem_addr), 0);
        tick(6);
        run_start();
        wait_done(200);
        gap_chk = 1'b0;
        chk("full_we_count", we_cnt - w0, 10);
        chk("full_pc", int'(pc), 9);
        chk("full_busy", int'(busy), 0);
        chk("full_error", int'(error), 0);
        chk("full_queue_empty", exp_q.size(), 0);

        // HALT at slot 2, restarted from DONE
        imem[2] = 18'h3C000;
        push_exp(2);
        w0 = we_cnt;
        a0 = as_cnt;
        run_start();
        wait_done(100);
        tick(3);
        chk("halt_we_count", we_cnt - w0, 2);
        chk("halt_alu_start_count", as_cnt - a0, 2);
        chk("halt_pc", int'(pc), 2);
        chk("halt_done_held", int'(done), 1);
        chk("halt_queue_empty", exp_q.size(), 0);

        // ALU timeout at slot 0
        load_prog();
        alu_en = 1'b0;
        w0 = we_cnt;
        run_start();
        wait_exec(4'd0, 20);
        c0 = cyc;
        wait_done(40);
        chk("timeout_exec_cycles", cyc - c0, 15);
        chk("timeout_error", int'(error), 1);
        chk("timeout_pc", int'(pc), 0);
        tick(3);
        chk("timeout_error_sticky", int'(error), 1);
        chk("timeout_we_count", we_cnt - w0, 0);

        // Restart clears error; decode of slot 0 visible from first EXEC cycle
        alu_en = 1'b1;
        push_exp(10);
        run_start();
        chk("restart_error_cleared", int'(error), 0);
        wait_exec(4'd0, 20);
        chk("decode_fields", int'({op_code, reg_id1, reg_id2, imm_value}),
            int'({4'h0, 3'd1, 3'd2, 8'h05}));
        wait_done(200);
        chk("restart_pc", int'(pc), 9);
        chk("restart_queue_empty", exp_q.size(), 0);

        // Reset while stalled in EXEC of slot 3, then restart from slot 0
        push_exp(3);
        stall_pc = 4'd3;
        stall_en = 1'b1;
        run_start();
        wait_exec(4'd3, 100);
        tick(1);
        chk("stalled_busy", int'(busy), 1);
        resetn = 1'b0;
        tick(1);
        chk("exec_reset_outputs", int'({busy, done, error, alu_start, rf_we, pc, imem_addr,
                                        op_code, reg_id1, reg_id2, imm_value}), 0);
        chk("exec_reset_queue_empty", exp_q.size(), 0);
        resetn   = 1'b1;
        stall_en = 1'b0;
        push_exp(10);
        tick(1);
        chk("rf_we_after_exec_reset", int'(rf_we), 0);
        w0 = we_cnt;
        run_start();
        chk("post_reset_pc", int'(pc), 0);
        chk("post_reset_busy", int'(busy), 1);
        wait_done(200);
        chk("post_reset_we_count", we_cnt - w0, 10);
        chk("post_reset_pc_final", int'(pc), 9);

`ifdef SINGLE_STEP_EN
        // Single-step: hold in PAUSE until a step pulse
        step = 1'b0;
        push_exp(10);
        w0 = we_cnt;
        a0 = as_cnt;
        run_start();
        wait_we(w0 + 1, 50);
        tick(5);
        chk("pause_busy", int'(busy), 1);
        chk("pause_done", int'(done), 0);
        chk("pause_pc", int'(pc), 1);
        chk("pause_alu_start_count", as_cnt - a0, 1);
        step = 1'b1;
        tick(1);
        step = 1'b0;
        wait_we(w0 + 2, 20);
        step = 1'b1;
        wait_done(200);
        chk("step_queue_empty", exp_q.size(), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter PROG_LEN, default 10, SHALL be the number of instruction-memory slots executed (legal range 1..16).
REQ-003 Parameter ALU_TIMEOUT, default 15, SHALL be the maximum cycles waited for alu_done before error.
REQ-004 Ports SHALL be:
- clock  in  1  rising-edge clock.
- resetn  in  1  synchronous active-low reset.
- start  in  1  level-sampled request to begin the program at slot 0.
- imem_addr  out  4  instruction-memory read address.
- imem_rdata  in  18  instruction word, valid 1 cycle after imem_addr.
- op_code  out  4  decoded bits [17:14].
- reg_id1  out  3  decoded bits [13:11].
- reg_id2  out  3  decoded bits [10:8].
- imm_value  out  8  decoded bits [7:0].
- alu_start  out  1  one-cycle pulse requesting the datapath operation.
- alu_done  in  1  datapath completion, sampled only in EXEC.
- rf_we  out  1  one-cycle register-file write strobe.
- pc  out  4  current slot index.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- error  out  1  sticky ALU-timeout flag.
- step  in  1  single-step advance; present only with SINGLE_STEP_EN.

Function
REQ-005 The FSM SHALL have states IDLE, FETCH, DECODE, EXEC, WB and DONE, plus PAUSE when SINGLE_STEP_EN is defined.
REQ-006 In IDLE with start=1, the FSM SHALL set pc=0, clear error, and enter FETCH on the next edge.
REQ-007 In FETCH, imem_addr SHALL equal pc, and the FSM SHALL enter DECODE after exactly 1 cycle.
REQ-008 In DECODE, op_code, reg_id1, reg_id2 and imm_value SHALL be registered from imem_rdata and held until the next DECODE.
REQ-009 In DECODE, if imem_rdata[17:14]==4'b1111 (HALT), the FSM SHALL enter DONE without asserting alu_start or rf_we; otherwise it SHALL enter EXEC.
REQ-010 alu_start SHALL be high for exactly the first cycle in EXEC.
REQ-011 The FSM SHALL leave EXEC for WB on the first edge where alu_done=1, including the same cycle alu_start is high (zero-wait datapath).
REQ-012 A wait counter SHALL count EXEC cycles; when it reaches ALU_TIMEOUT without alu_done, error SHALL set to 1, no rf_we SHALL be issued, and the FSM SHALL enter DONE.
REQ-013 In WB, rf_we SHALL be high for exactly 1 cycle.
REQ-014 In WB, if pc==PROG_LEN-1, the FSM SHALL enter DONE with pc unchanged; otherwise pc SHALL increment by 1 and the FSM SHALL enter FETCH.
REQ-015 Minimum latency per instruction SHALL be 4 cycles (FETCH, DECODE, EXEC, WB).
REQ-016 In DONE, done=1; start=1 SHALL restart exactly as in REQ-006; start=0 SHALL hold DONE.
REQ-017 start SHALL be ignored in every state other than IDLE and DONE.
REQ-018 pc SHALL never exceed PROG_LEN-1 and SHALL never wrap to 0 except through REQ-006.
REQ-019 error SHALL remain set through DONE and IDLE until the next start or reset.

Reset
REQ-020 When resetn=0 at a clock edge, the block SHALL enter IDLE regardless of state, including mid-EXEC.
REQ-021 Reset SHALL set pc, imem_addr, op_code, reg_id1, reg_id2, imm_value and the wait counter to 0.
REQ-022 Reset SHALL set alu_start, rf_we, busy, done and error to 0.
REQ-023 An rf_we pulse SHALL NOT be issued on the cycle after reset deasserts.

Configuration
REQ-024 Macro SINGLE_STEP_EN, when defined, SHALL add input step and state PAUSE.
REQ-025 With SINGLE_STEP_EN defined, WB SHALL go to PAUSE instead of FETCH; PAUSE SHALL go to FETCH on the first cycle step=1, with busy=1 held throughout PAUSE.
REQ-026 With SINGLE_STEP_EN defined, WB on the last slot SHALL still go directly to DONE.
REQ-027 Without SINGLE_STEP_EN, neither the step port nor PAUSE SHALL exist, and behaviour SHALL follow REQ-014.

Verification
REQ-028 The bench SHALL cover: 10-slot program with no HALT, alu_done tied 1, start pulse -> 10 rf_we pulses 4 cycles apart, done=1, pc=9.
REQ-029 The bench SHALL cover: slot 2 = 18'h3C000 (HALT) -> exactly 2 rf_we pulses, done=1, pc=2, no alu_start for slot 2.
REQ-030 The bench SHALL cover: alu_done held 0 at slot 0 -> error=1 after 15 EXEC cycles, DONE state, rf_we never asserted.
REQ-031 The bench SHALL cover: slot 0 = 18'b0000_001_010_00000101 -> op_code=0, reg_id1=1, reg_id2=2, imm_value=5 from the cycle after DECODE.
REQ-032 The bench SHALL cover: resetn=0 during EXEC of slot 3 -> next cycle IDLE, all outputs 0, a restart begins at pc=0.
REQ-033 The bench SHALL cover: with SINGLE_STEP_EN, step held 0 after slot 0 WB -> FSM stays in PAUSE with busy=1; a step pulse -> FETCH of slot 1.
